encoder_8_3_queue: RTL

ENCODER_8_3_QUEUE -- requirements
Module: encoder_8_3_queue

---
 rtl/enc_pkg.sv | 7 +
 rtl/prio_enc_8_3.sv | 28 ++
 rtl/encoder_8_3_queue.sv | 76 +++++++
 3 files changed

// File: rtl/enc_pkg.sv
// rtl/enc_pkg.sv - shared widths for the 8-to-3 encoder queue
package enc_pkg;

    localparam int ENC_IN_W  = 8;
    localparam int ENC_OUT_W = 3;

endpackage

// File: rtl/prio_enc_8_3.sv
// rtl/prio_enc_8_3.sv - combinational 8-to-3 priority encoder, direction selectable
module prio_enc_8_3
    import enc_pkg::*;
#(
    parameter bit LSB_FIRST = 1'b0
) (
    input  logic [ENC_IN_W-1:0]  i_vec,
    output logic [ENC_OUT_W-1:0] o_idx,
    output logic                 o_any
);

    // Scan so that the last set bit visited is the winner: ascending scan
    // keeps the highest index, descending scan keeps the lowest.
    always_comb begin
        o_idx = '0;
        o_any = |i_vec;
        if (LSB_FIRST) begin
            for (int i = ENC_IN_W - 1; i >= 0; i--) begin
                if (i_vec[i]) o_idx = ENC_OUT_W'(i);
            end
        end else begin
            for (int i = 0; i < ENC_IN_W; i++) begin
                if (i_vec[i]) o_idx = ENC_OUT_W'(i);
            end
        end
    end

endmodule

// File: rtl/encoder_8_3_queue.sv
// rtl/encoder_8_3_queue.sv - pending-request register drained one code per accept
module encoder_8_3_queue
    import enc_pkg::*;
#(
    parameter bit LSB_FIRST = 1'b0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 E,
    input  logic [ENC_IN_W-1:0]  In,
    output logic [ENC_OUT_W-1:0] Out,
    output logic                 Valid,
    input  logic                 Ready,
    output logic                 Busy
);

    logic [ENC_IN_W-1:0]  r_pending;
    logic [ENC_OUT_W-1:0] r_out;
    logic                 r_valid;

    logic [ENC_OUT_W-1:0] w_idx;
    logic                 w_any;
    logic                 w_slot_free;
    logic                 w_load;
    logic [ENC_IN_W-1:0]  w_clr;
    logic [ENC_IN_W-1:0]  w_set;

    // Priority is taken from the registered pending vector only, never live In.
    prio_enc_8_3 #(
        .LSB_FIRST (LSB_FIRST)
    ) u_prio (
        .i_vec (r_pending),
        .o_idx (w_idx),
        .o_any (w_any)
    );

    assign w_slot_free = !r_valid || Ready;
    assign w_load      = w_slot_free && w_any;
    assign w_set       = E ? In : '0;

    // One-hot of the bit handed to Out this edge; zero when nothing is loaded.
    always_comb begin
        w_clr = '0;
        if (w_load) w_clr = ENC_IN_W'(1) << w_idx;
    end

    // Pending accumulates new requests; set is OR-ed after the clear so a
    // re-asserted bit survives the edge that serves it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pending <= '0;
        end else begin
            r_pending <= (r_pending & ~w_clr) | w_set;
        end
    end

    // Output slot: refill when free, otherwise hold the unaccepted code.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out   <= '0;
            r_valid <= 1'b0;
        end else if (w_slot_free) begin
            if (w_any) begin
                r_out   <= w_idx;
                r_valid <= 1'b1;
            end else begin
                r_valid <= 1'b0;
            end
        end
    end

    assign Out   = r_out;
    assign Valid = r_valid;
    assign Busy  = (|r_pending) || r_valid;

endmodule
